// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 sequencer: FSM states, stage encoding,
// error flag positions and S-memory geometry.
package arc4_pkg;

  localparam int S_ADDR_W = 8;
  localparam int S_DATA_W = 8;

  localparam logic [1:0] STG_NONE = 2'd0;
  localparam logic [1:0] STG_INIT = 2'd1;
  localparam logic [1:0] STG_KSA  = 2'd2;
  localparam logic [1:0] STG_PRGA = 2'd3;

  localparam int ERR_WDOG  = 0;
  localparam int ERR_ILLWR = 1;

  typedef enum logic [3:0] {
    IDLE,
    INIT_REQ, INIT_ACK, INIT_RUN,
    KSA_REQ,  KSA_ACK,  KSA_RUN,
    PRGA_REQ, PRGA_ACK, PRGA_RUN,
    DONE
  } state_t;

  // Which engine owns the S-memory port in a given state
  function automatic logic [1:0] stage_of(input state_t s);
    case (s)
      INIT_REQ, INIT_ACK, INIT_RUN: stage_of = STG_INIT;
      KSA_REQ,  KSA_ACK,  KSA_RUN:  stage_of = STG_KSA;
      PRGA_REQ, PRGA_ACK, PRGA_RUN: stage_of = STG_PRGA;
      default:                      stage_of = STG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/arc4_mem_mux.sv
// Combinational S-memory port mux: forwards only the granted engine and
// flags any write enable raised by an engine that does not hold the grant.
module arc4_mem_mux
  import arc4_pkg::*;
#(
  parameter int ADDR_W = S_ADDR_W,
  parameter int DATA_W = S_DATA_W
) (
  input  logic [1:0]        stage,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic              init_wren,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic              ksa_wren,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren,
  output logic              illegal_wr
);

  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (stage)
      STG_INIT: begin
        s_addr   = init_addr;
        s_wrdata = init_wrdata;
        s_wren   = init_wren;
      end
      STG_KSA: begin
        s_addr   = ksa_addr;
        s_wrdata = ksa_wrdata;
        s_wren   = ksa_wren;
      end
      STG_PRGA: begin
        s_addr   = prga_addr;
        s_wrdata = prga_wrdata;
        s_wren   = prga_wren;
      end
      default: ;
    endcase
  end

  assign illegal_wr = (init_wren && (stage != STG_INIT)) ||
                      (ksa_wren  && (stage != STG_KSA))  ||
                      (prga_wren && (stage != STG_PRGA));

endmodule

// File: rtl/arc4_seq_ctrl.sv
// ARC4 top-level sequencer: runs init, ksa, prga in order with a
// per-engine watchdog, and owns the grant on the shared S-memory port.
module arc4_seq_ctrl
  import arc4_pkg::*;
#(
  parameter int ADDR_W  = S_ADDR_W,
  parameter int DATA_W  = S_DATA_W,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic [1:0]        err,
  output logic [1:0]        stage,
  output logic              init_en,
  output logic              ksa_en,
  output logic              prga_en,
  input  logic              init_rdy,
  input  logic              ksa_rdy,
  input  logic              prga_rdy,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [ADDR_W-1:0] ksa_addr,
  input  logic [ADDR_W-1:0] prga_addr,
  input  logic [DATA_W-1:0] init_wrdata,
  input  logic [DATA_W-1:0] ksa_wrdata,
  input  logic [DATA_W-1:0] prga_wrdata,
  input  logic              init_wren,
  input  logic              ksa_wren,
  input  logic              prga_wren,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wrdata,
  output logic              s_wren
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state, state_next;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_active, wd_hit, req_entry, illegal_wr;
  logic            init_go, ksa_go, prga_go;

  assign wd_active = (state == INIT_ACK) || (state == INIT_RUN) ||
                     (state == KSA_ACK)  || (state == KSA_RUN)  ||
                     (state == PRGA_ACK) || (state == PRGA_RUN);
  assign wd_hit    = (TIMEOUT != 0) && wd_active && (wd_cnt == WD_LAST);
  assign req_entry = (state_next != state) &&
                     ((state_next == INIT_REQ) || (state_next == KSA_REQ) ||
                      (state_next == PRGA_REQ));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Timeout is tested before any rdy edge so an expiring engine never advances
  always_comb begin
    state_next = state;
    init_go    = 1'b0;
    ksa_go     = 1'b0;
    prga_go    = 1'b0;
    case (state)
      IDLE:     if (en) state_next = INIT_REQ;
      INIT_REQ: if (init_rdy) begin init_go = 1'b1; state_next = INIT_ACK; end
      INIT_ACK: if (wd_hit) state_next = IDLE; else if (!init_rdy) state_next = INIT_RUN;
      INIT_RUN: if (wd_hit) state_next = IDLE; else if (init_rdy)  state_next = KSA_REQ;
      KSA_REQ:  if (ksa_rdy) begin ksa_go = 1'b1; state_next = KSA_ACK; end
      KSA_ACK:  if (wd_hit) state_next = IDLE; else if (!ksa_rdy)  state_next = KSA_RUN;
      KSA_RUN:  if (wd_hit) state_next = IDLE; else if (ksa_rdy)   state_next = PRGA_REQ;
      PRGA_REQ: if (prga_rdy) begin prga_go = 1'b1; state_next = PRGA_ACK; end
      PRGA_ACK: if (wd_hit) state_next = IDLE; else if (!prga_rdy) state_next = PRGA_RUN;
      PRGA_RUN: if (wd_hit) state_next = IDLE; else if (prga_rdy)  state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                           wd_cnt <= '0;
    else if (req_entry)                   wd_cnt <= '0;
    else if (wd_active && wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err <= '0;
    end else begin
      if (wd_hit)     err[ERR_WDOG]  <= 1'b1;
      if (illegal_wr) err[ERR_ILLWR] <= 1'b1;
    end
  end

  // Start pulses are masked by reset so an abort cannot kick an engine
  assign init_en = init_go & rst_n;
  assign ksa_en  = ksa_go  & rst_n;
  assign prga_en = prga_go & rst_n;
  assign rdy     = (state == IDLE);
  assign stage   = stage_of(state);

  arc4_mem_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_mux (
    .stage       (stage),
    .init_addr   (init_addr),
    .init_wrdata (init_wrdata),
    .init_wren   (init_wren),
    .ksa_addr    (ksa_addr),
    .ksa_wrdata  (ksa_wrdata),
    .ksa_wren    (ksa_wren),
    .prga_addr   (prga_addr),
    .prga_wrdata (prga_wrdata),
    .prga_wren   (prga_wren),
    .s_addr      (s_addr),
    .s_wrdata    (s_wrdata),
    .s_wren      (s_wren),
    .illegal_wr  (illegal_wr)
  );

endmodule

// File: tb/tb_arc4_seq_ctrl.sv
// Directed bench for arc4_seq_ctrl: one default instance for the nominal
// flow and one with TIMEOUT=16 and a stuck ksa engine for the watchdog.
module tb_arc4_seq_ctrl;
  import arc4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       en_a, rdy_a, s_wren_a;
  logic [1:0] err_a, stage_a;
  logic [7:0] s_addr_a, s_wrdata_a;
  logic [7:0] addr[3];
  logic [7:0] wrd[3];
  logic       wren[3];

  logic       en_b, rdy_b, s_wren_b;
  logic [1:0] err_b, stage_b;
  logic [7:0] s_addr_b, s_wrdata_b;

  // engines 0..2 serve dut_a, 3..5 serve dut_b; latency 0 means stuck busy
  logic eng_en[6];
  logic eng_rdy[6];
  int   lat[6]    = '{256, 768, 10, 3, 0, 10};
  int   cnt[6];
  int   pulses[6] = '{default: 0};

  int vectors = 0;
  int miscompares = 0;

  arc4_seq_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .rdy(rdy_a), .err(err_a), .stage(stage_a),
    .init_en(eng_en[0]), .ksa_en(eng_en[1]), .prga_en(eng_en[2]),
    .init_rdy(eng_rdy[0]), .ksa_rdy(eng_rdy[1]), .prga_rdy(eng_rdy[2]),
    .init_addr(addr[0]), .ksa_addr(addr[1]), .prga_addr(addr[2]),
    .init_wrdata(wrd[0]), .ksa_wrdata(wrd[1]), .prga_wrdata(wrd[2]),
    .init_wren(wren[0]), .ksa_wren(wren[1]), .prga_wren(wren[2]),
    .s_addr(s_addr_a), .s_wrdata(s_wrdata_a), .s_wren(s_wren_a)
  );

  arc4_seq_ctrl #(.TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .rdy(rdy_b), .err(err_b), .stage(stage_b),
    .init_en(eng_en[3]), .ksa_en(eng_en[4]), .prga_en(eng_en[5]),
    .init_rdy(eng_rdy[3]), .ksa_rdy(eng_rdy[4]), .prga_rdy(eng_rdy[5]),
    .init_addr(8'h00), .ksa_addr(8'h00), .prga_addr(8'h00),
    .init_wrdata(8'h00), .ksa_wrdata(8'h00), .prga_wrdata(8'h00),
    .init_wren(1'b0), .ksa_wren(1'b0), .prga_wren(1'b0),
    .s_addr(s_addr_b), .s_wrdata(s_wrdata_b), .s_wren(s_wren_b)
  );

  always @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (!rst_n) begin
        eng_rdy[i] <= 1'b1;
        cnt[i]     <= 0;
      end else if (eng_rdy[i] && eng_en[i]) begin
        eng_rdy[i] <= 1'b0;
        cnt[i]     <= lat[i];
      end else if (!eng_rdy[i] && lat[i] != 0) begin
        if (cnt[i] <= 1) eng_rdy[i] <= 1'b1;
        else             cnt[i]     <= cnt[i] - 1;
      end
      if (eng_en[i] === 1'b1) pulses[i] <= pulses[i] + 1;
    end
  end

  logic [1:0] prev_stage = 2'd0;
  logic [1:0] stage_log[$];
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (stage_a !== prev_stage) stage_log.push_back(stage_a);
    prev_stage = stage_a;
    if (rst_n && rdy_a === 1'b0 && stage_a === STG_NONE) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit on_b);
    if (on_b) en_b = 1'b1; else en_a = 1'b1;
    @(negedge clk);
    en_a = 1'b0;
    en_b = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int n, log0, done0;
    int p0[3];

    rst_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    for (int i = 0; i < 3; i++) begin addr[i] = 8'h00; wrd[i] = 8'h00; wren[i] = 1'b0; end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    checkOutput("reset_rdy",    rdy_a, 1);
    checkOutput("reset_stage",  stage_a, 0);
    checkOutput("reset_err",    err_a, 0);
    checkOutput("reset_en",     {eng_en[0], eng_en[1], eng_en[2]}, 0);
    checkOutput("reset_s_wren", s_wren_a, 0);
    checkOutput("reset_rdy_b",  rdy_b, 1);
    addr[0] = 8'h55; wrd[0] = 8'h66;
    #1;
    checkOutput("idle_s_addr",   s_addr_a, 0);
    checkOutput("idle_s_wrdata", s_wrdata_a, 0);
    addr[0] = 8'h00; wrd[0] = 8'h00;

    // watchdog on dut_b: ksa accepts, then never finishes
    applyStimulus(1);
    checkOutput("b_init_en_latency", eng_en[3], 1);
    checkOutput("b_rdy_drop", rdy_b, 0);
    n = 0;
    while (!(stage_b == STG_KSA && eng_en[4] === 1'b1) && n < 50) begin @(negedge clk); n++; end
    checkOutput("b_wait_ksa_req", n < 50, 1);
    repeat (16) @(negedge clk);
    checkOutput("wd_stage_before", stage_b, STG_KSA);
    checkOutput("wd_err_before", err_b, 2'b00);
    @(negedge clk);
    checkOutput("wd_err_after", err_b, 2'b01);
    checkOutput("wd_stage_after", stage_b, STG_NONE);
    checkOutput("wd_rdy_after", rdy_b, 1);
    repeat (20) @(negedge clk);
    checkOutput("wd_no_prga_en", pulses[5], 0);
    checkOutput("wd_ksa_en_once", pulses[4], 1);

    // nominal run on dut_a with mux checks and an ignored en mid-run
    log0 = stage_log.size(); done0 = done_cnt;
    applyStimulus(0);
    checkOutput("init_en_latency", eng_en[0], 1);
    checkOutput("run_stage_init", stage_a, STG_INIT);
    checkOutput("run_rdy_low", rdy_a, 0);
    n = 0;
    while (!(stage_a == STG_KSA && eng_rdy[1] == 1'b0) && n < 400) begin @(negedge clk); n++; end
    checkOutput("wait_ksa_busy", n < 400, 1);
    @(negedge clk);
    addr[1] = 8'h3C; wrd[1] = 8'hA5; wren[1] = 1'b1;
    #1;
    checkOutput("mux_ksa_addr", s_addr_a, 8'h3C);
    checkOutput("mux_ksa_wrdata", s_wrdata_a, 8'hA5);
    checkOutput("mux_ksa_wren", s_wren_a, 1);
    addr[2] = 8'h77; wrd[2] = 8'h11; wren[2] = 1'b1;
    #1;
    checkOutput("mux_block_addr", s_addr_a, 8'h3C);
    checkOutput("mux_block_wrdata", s_wrdata_a, 8'hA5);
    checkOutput("mux_block_wren", s_wren_a, 1);
    @(negedge clk);
    checkOutput("illegal_wr_err", err_a, 2'b10);
    wren[1] = 1'b0; wren[2] = 1'b0;
    applyStimulus(0);
    n = 0;
    while (!(rdy_a == 1'b0 && stage_a == STG_NONE) && n < 1200) begin @(negedge clk); n++; end
    checkOutput("wait_done", n < 1200, 1);
    @(negedge clk);
    checkOutput("rdy_after_done", rdy_a, 1);
    repeat (10) @(negedge clk);
    checkOutput("single_done", done_cnt - done0, 1);
    checkOutput("no_restart_rdy", rdy_a, 1);
    checkOutput("pulses_init", pulses[0], 1);
    checkOutput("pulses_ksa", pulses[1], 1);
    checkOutput("pulses_prga", pulses[2], 1);
    checkOutput("stage_log_len", stage_log.size() - log0, 4);
    if (stage_log.size() - log0 == 4) begin
      checkOutput("stage_seq_0", stage_log[log0],     STG_INIT);
      checkOutput("stage_seq_1", stage_log[log0 + 1], STG_KSA);
      checkOutput("stage_seq_2", stage_log[log0 + 2], STG_PRGA);
      checkOutput("stage_seq_3", stage_log[log0 + 3], STG_NONE);
    end

    // abort during PRGA_RUN, then a clean pass
    for (int i = 0; i < 3; i++) p0[i] = pulses[i];
    done0 = done_cnt;
    applyStimulus(0);
    n = 0;
    while (!(stage_a == STG_PRGA && eng_rdy[2] == 1'b0) && n < 1200) begin @(negedge clk); n++; end
    checkOutput("wait_prga_busy", n < 1200, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_en_low", {eng_en[0], eng_en[1], eng_en[2]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_rdy", rdy_a, 1);
    checkOutput("abort_stage", stage_a, STG_NONE);
    checkOutput("abort_err", err_a, 0);
    checkOutput("abort_pulses", {pulses[0] - p0[0], pulses[1] - p0[1], pulses[2] - p0[2]},
                {32'd1, 32'd1, 32'd1});
    checkOutput("abort_no_done", done_cnt - done0, 0);

    for (int i = 0; i < 3; i++) p0[i] = pulses[i];
    applyStimulus(0);
    n = 0;
    while (!(rdy_a == 1'b0 && stage_a == STG_NONE) && n < 1200) begin @(negedge clk); n++; end
    checkOutput("clean_wait_done", n < 1200, 1);
    @(negedge clk);
    checkOutput("clean_rdy", rdy_a, 1);
    checkOutput("clean_err", err_a, 0);
    checkOutput("clean_pulses", {pulses[0] - p0[0], pulses[1] - p0[1], pulses[2] - p0[2]},
                {32'd1, 32'd1, 32'd1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
